// File: rtl/dff_asr_sequencer_if.sv
// -----------------------------------------------------------------------------
// dff_asr_sequencer_if
//
// Bundles the request inputs and the pin/status outputs of dff_asr_sequencer.
//
// Signals
//   req_reset : request one clear pulse on the downstream async flops
//   req_set   : request one preset pulse on the downstream async flops
//   RESETN    : active-low clear to the flops' RESETN pins
//   SETN      : active-low preset to the flops' SETN pins
//   d_en      : downstream flops may capture D
//   busy      : sequencer is not idle
//   done      : one-cycle pulse on return to idle
//   drop      : one-cycle pulse when a request is discarded
//
// Modports
//   master : the requester (drives req_*, observes everything else)
//   slave  : the sequencer (observes req_*, drives everything else)
// -----------------------------------------------------------------------------
interface dff_asr_sequencer_if;
  logic req_reset;
  logic req_set;
  logic RESETN;
  logic SETN;
  logic d_en;
  logic busy;
  logic done;
  logic drop;

  modport master (
    output req_reset,
    output req_set,
    input  RESETN,
    input  SETN,
    input  d_en,
    input  busy,
    input  done,
    input  drop
  );

  modport slave (
    input  req_reset,
    input  req_set,
    output RESETN,
    output SETN,
    output d_en,
    output busy,
    output done,
    output drop
  );
endinterface

// File: rtl/dff_asr_sequencer.sv
// -----------------------------------------------------------------------------
// dff_asr_sequencer
//
// Generates clean, non-overlapping clear/preset pulses for a bank of flops
// with asynchronous RESETN/SETN pins, followed by a recovery window during
// which the flops must not capture D. Every output is a flop, so the async
// pins never see combinational glitches.
//
// Sequence: IDLE -> ASSERT_R or ASSERT_S (pin low PULSE_CYCLES cycles)
//                -> RECOVER (d_en low RECOVERY_CYCLES cycles) -> IDLE (done)
//
// A reset request preempts a set pulse or a recovery window. Requests that
// arrive while a conflicting pulse is in flight (set during ASSERT_R or
// RECOVER, reset during ASSERT_R, or a set that loses to a simultaneous
// reset) are either buffered or discarded, depending on the build:
//   DFF_ASR_SEQUENCER_PENDING_EN defined   : one pending flag per request
//     type; on leaving RECOVER a pending reset (first) or set starts the next
//     pulse instead of returning to IDLE; a request that finds its flag
//     already set is dropped.
//   DFF_ASR_SEQUENCER_PENDING_EN undefined : such requests are dropped.
// A set request during ASSERT_S duplicates the pulse in progress and is
// dropped in both builds.
//
// Parameters
//   PULSE_CYCLES    : cycles RESETN/SETN held low, 1..2^CNT_W-1
//   RECOVERY_CYCLES : cycles of d_en low after the pulse, 1..2^CNT_W-1
//   CNT_W           : width of the shared down-counter
//
// Ports
//   CLK   : single clock, all state updates on its rising edge
//   RESET : synchronous, active-high; forces a clear pulse from ASSERT_R
//   bus   : dff_asr_sequencer_if.slave (requests in, pins/status out)
// -----------------------------------------------------------------------------
module dff_asr_sequencer #(
  parameter int PULSE_CYCLES    = 2,
  parameter int RECOVERY_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dff_asr_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT_R = 2'd1,
    ASSERT_S = 2'd2,
    RECOVER  = 2'd3
  } state_t;

  // The counter holds "cycles remaining minus one", so a load of N-1 gives
  // exactly N cycles in the state before the zero test moves on.
  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVERY_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Registered outputs
  logic resetn_q;
  logic setn_q;
  logic d_en_q;
  logic busy_q;
  logic done_q;
  logic drop_q;
  logic drop_nxt;

  // Per-cycle request classification produced by the FSM decode
  logic start_r;    // entering ASSERT_R fresh this edge
  logic start_s;    // entering ASSERT_S fresh this edge
  logic extra_r;    // reset request that cannot be serviced right now
  logic extra_s;    // set request that cannot be serviced right now
  logic dup_s;      // set request during an ongoing set pulse

  // View of the buffered requests as seen by the RECOVER exit decision
  logic exit_to_r;
  logic exit_to_s;

`ifdef DFF_ASR_SEQUENCER_PENDING_EN
  logic pend_r;
  logic pend_s;
  logic pend_r_nxt;
  logic pend_s_nxt;

  // A set arriving on the very edge recovery ends is buffered and
  // immediately consumed, so it counts toward the exit decision.
  assign exit_to_r = pend_r;
  assign exit_to_s = pend_s | bus.req_set;
`else
  assign exit_to_r = 1'b0;
  assign exit_to_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default before the case so that
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_r   = 1'b0;
    start_s   = 1'b0;
    extra_r   = 1'b0;
    extra_s   = 1'b0;
    dup_s     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req_reset) begin
          start_r = 1'b1;
          extra_s = bus.req_set;          // reset wins a simultaneous request
        end else if (bus.req_set) begin
          start_s = 1'b1;
        end
      end

      ASSERT_R: begin
        extra_r = bus.req_reset;
        extra_s = bus.req_set;
        if (cnt == '0) begin
          state_nxt = RECOVER;
          cnt_nxt   = RECOVER_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ASSERT_S: begin
        if (bus.req_reset) begin
          start_r = 1'b1;                 // preempt: SETN releases this edge
          extra_s = bus.req_set;
        end else begin
          dup_s = bus.req_set;
          if (cnt == '0) begin
            state_nxt = RECOVER;
            cnt_nxt   = RECOVER_LOAD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end

      RECOVER: begin
        extra_s = bus.req_set;
        if (bus.req_reset) begin
          start_r = 1'b1;
        end else if (cnt == '0) begin
          if (exit_to_r) begin
            start_r = 1'b1;
          end else if (exit_to_s) begin
            start_s = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (start_r) begin
      state_nxt = ASSERT_R;
      cnt_nxt   = PULSE_LOAD;
    end else if (start_s) begin
      state_nxt = ASSERT_S;
      cnt_nxt   = PULSE_LOAD;
    end
  end

  // ---------------------------------------------------------------------------
  // Request buffering / discard
  // ---------------------------------------------------------------------------
`ifdef DFF_ASR_SEQUENCER_PENDING_EN
  always_comb begin
    pend_r_nxt = pend_r;
    pend_s_nxt = pend_s;
    drop_nxt   = dup_s;

    if (extra_r) begin
      if (pend_r) drop_nxt   = 1'b1;
      else        pend_r_nxt = 1'b1;
    end
    if (extra_s) begin
      if (pend_s) drop_nxt   = 1'b1;
      else        pend_s_nxt = 1'b1;
    end

    // Starting a pulse satisfies any buffered request of the same type.
    if (start_r) pend_r_nxt = 1'b0;
    if (start_s) pend_s_nxt = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_r <= 1'b0;
      pend_s <= 1'b0;
    end else begin
      pend_r <= pend_r_nxt;
      pend_s <= pend_s_nxt;
    end
  end
`else
  always_comb begin
    drop_nxt = dup_s | extra_r | extra_s;
  end
`endif

  // ---------------------------------------------------------------------------
  // State, counter and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  // Outputs are decoded from the next state, so each pin changes on the same
  // edge as the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ASSERT_R;
      cnt      <= PULSE_LOAD;
      resetn_q <= 1'b0;
      setn_q   <= 1'b1;
      d_en_q   <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      resetn_q <= (state_nxt != ASSERT_R);
      setn_q   <= (state_nxt != ASSERT_S);
      d_en_q   <= (state_nxt == IDLE);
      busy_q   <= (state_nxt != IDLE);
      done_q   <= (state_nxt == IDLE) && (state != IDLE);
      drop_q   <= drop_nxt;
    end
  end

  assign bus.RESETN = resetn_q;
  assign bus.SETN   = setn_q;
  assign bus.d_en   = d_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.drop   = drop_q;

endmodule

// File: tb/tb_dff_asr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dff_asr_sequencer
//
// Drives dff_asr_sequencer (PULSE_CYCLES=2, RECOVERY_CYCLES=3) with directed
// scenarios followed by random requests/resets, and compares every cycle
// against a behavioural model that tracks "cycles left" in the pulse and in
// the recovery window plus the buffered requests.
// Build with +define+DFF_ASR_SEQUENCER_PENDING_EN to exercise buffering.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dff_asr_sequencer;

  localparam int P_CYC = 2;
  localparam int R_CYC = 3;
  localparam int CW    = 4;

`ifdef DFF_ASR_SEQUENCER_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  dff_asr_sequencer_if bus ();

  dff_asr_sequencer #(
    .PULSE_CYCLES    (P_CYC),
    .RECOVERY_CYCLES (R_CYC),
    .CNT_W           (CW)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   kind      : which pin is low right now ('R', 'S' or none)
  //   pulse_left: cycles of the current pulse still to run, this one included
  //   rec_left  : cycles of recovery still to run, this one included
  // ---------------------------------------------------------------------------
  localparam int K_NONE = 0;
  localparam int K_R    = 1;
  localparam int K_S    = 2;

  int m_kind;
  int m_pulse_left;
  int m_rec_left;
  bit m_pend_r;
  bit m_pend_s;
  bit m_done;
  bit m_drop;

  function automatic void m_start_r();
    m_kind = K_R; m_pulse_left = P_CYC; m_rec_left = 0; m_pend_r = 1'b0;
  endfunction

  function automatic void m_start_s();
    m_kind = K_S; m_pulse_left = P_CYC; m_rec_left = 0; m_pend_s = 1'b0;
  endfunction

  // A request that cannot be serviced now: buffer it or throw it away.
  function automatic void m_extra_r();
    if (PEND && !m_pend_r) m_pend_r = 1'b1;
    else                   m_drop   = 1'b1;
  endfunction

  function automatic void m_extra_s();
    if (PEND && !m_pend_s) m_pend_s = 1'b1;
    else                   m_drop   = 1'b1;
  endfunction

  function automatic void m_pulse_tick();
    m_pulse_left--;
    if (m_pulse_left == 0) begin
      m_kind     = K_NONE;
      m_rec_left = R_CYC;
    end
  endfunction

  function automatic void model_step(input bit rr, input bit rs, input bit rst_i);
    m_done = 1'b0;
    m_drop = 1'b0;
    if (rst_i) begin
      m_start_r();
      m_pend_s = 1'b0;
      return;
    end
    if (m_kind == K_R) begin
      if (rr) m_extra_r();
      if (rs) m_extra_s();
      m_pulse_tick();
    end else if (m_kind == K_S) begin
      if (rr) begin
        m_start_r();
        if (rs) m_extra_s();
      end else begin
        if (rs) m_drop = 1'b1;
        m_pulse_tick();
      end
    end else if (m_rec_left > 0) begin
      if (rs) m_extra_s();
      if (rr) m_start_r();
      else begin
        m_rec_left--;
        if (m_rec_left == 0) begin
          if (m_pend_r)      m_start_r();
          else if (m_pend_s) m_start_s();
          else               m_done = 1'b1;
        end
      end
    end else begin
      if (rr) begin
        m_start_r();
        if (rs) m_extra_s();
      end else if (rs) begin
        m_start_s();
      end
    end
  endfunction

  task automatic compare_all();
    bit idle;
    idle = (m_kind == K_NONE) && (m_rec_left == 0);
    check("RESETN", 32'(bus.RESETN), 32'(m_kind != K_R));
    check("SETN",   32'(bus.SETN),   32'(m_kind != K_S));
    check("d_en",   32'(bus.d_en),   32'(idle));
    check("busy",   32'(bus.busy),   32'(!idle));
    check("done",   32'(bus.done),   32'(m_done));
    check("drop",   32'(bus.drop),   32'(m_drop));
    check("pins_not_both_low", 32'(bus.RESETN | bus.SETN), 32'd1);
    check("d_en_only_when_released",
          32'(bus.d_en & !(bus.RESETN & bus.SETN)), 32'd0);
  endtask

  // One clock: inputs change on the falling edge, the model steps on the
  // rising edge, outputs are sampled 1ns later.
  task automatic tick(input bit rr, input bit rs, input bit rst_i);
    @(negedge clk);
    bus.req_reset = rr;
    bus.req_set   = rs;
    rst           = rst_i;
    @(posedge clk);
    model_step(rr, rs, rst_i);
    #1;
    compare_all();
  endtask

  // Observe the current sample (index 0) and up to 11 idle cycles after it,
  // measuring pin-low durations, recovery length and the first done pulse.
  task automatic measure(output int rl, output int sl, output int rec,
                         output int done_at);
    rl = 0; sl = 0; rec = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 1'b0);
      if (!bus.RESETN) rl++;
      if (!bus.SETN)   sl++;
      if (bus.RESETN && bus.SETN && !bus.d_en) rec++;
      if (bus.done && done_at < 0) done_at = i;
    end
  endtask

  initial begin
    int rl, sl, rec, done_at;
    bit rr, rs, rx;

    bus.req_reset = 1'b0;
    bus.req_set   = 1'b0;
    m_kind = K_NONE; m_pulse_left = 0; m_rec_left = 0;
    m_pend_r = 1'b0; m_pend_s = 1'b0; m_done = 1'b0; m_drop = 1'b0;

    // RESET held 4 cycles, then released
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    check("rst_resetn_low", 32'(bus.RESETN), 32'd0);
    check("rst_busy",       32'(bus.busy),   32'd1);
    measure(rl, sl, rec, done_at);
    check("rst_pulse_len",   32'(rl),      32'd2);
    check("rst_recover_len", 32'(rec),     32'd3);
    check("rst_done_at",     32'(done_at), 32'd5);
    check("rst_idle_d_en",   32'(bus.d_en), 32'd1);
    check("rst_idle_busy",   32'(bus.busy), 32'd0);

    // Set pulse from IDLE
    tick(1'b0, 1'b1, 1'b0);
    measure(rl, sl, rec, done_at);
    check("set_pulse_len",   32'(sl),      32'd2);
    check("set_resetn_low",  32'(rl),      32'd0);
    check("set_recover_len", 32'(rec),     32'd3);
    check("set_done_at",     32'(done_at), 32'd5);

    // Simultaneous reset and set in IDLE
    tick(1'b1, 1'b1, 1'b0);
    check("both_drop", 32'(bus.drop), 32'(!PEND));
    measure(rl, sl, rec, done_at);
    check("both_reset_len", 32'(rl),      32'd2);
    check("both_set_len",   32'(sl),      PEND ? 32'd2 : 32'd0);
    check("both_done_at",   32'(done_at), PEND ? 32'd10 : 32'd5);

    // Reset request in the middle of a set pulse
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("preempt_setn",   32'(bus.SETN),   32'd1);
    check("preempt_resetn", 32'(bus.RESETN), 32'd0);
    measure(rl, sl, rec, done_at);
    check("preempt_reset_len", 32'(rl),      32'd2);
    check("preempt_done_at",   32'(done_at), 32'd5);

    // RESET during RECOVER, with a set buffered beforehand (pending build)
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("rec_state_d_en", 32'(bus.d_en), 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_in_rec_resetn", 32'(bus.RESETN), 32'd0);
    check("rst_in_rec_d_en",   32'(bus.d_en),   32'd0);
    measure(rl, sl, rec, done_at);
    check("rst_in_rec_reset_len", 32'(rl),      32'd2);
    check("rst_in_rec_no_set",    32'(sl),      32'd0);
    check("rst_in_rec_done_at",   32'(done_at), 32'd5);

    // Two set requests during a reset pulse
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("set1_drop", 32'(bus.drop), 32'(!PEND));
    tick(1'b0, 1'b1, 1'b0);
    check("set2_drop", 32'(bus.drop), 32'd1);
    measure(rl, sl, rec, done_at);
    check("set_twice_len",     32'(sl),      PEND ? 32'd2 : 32'd0);
    check("set_twice_done_at", 32'(done_at), PEND ? 32'd8 : 32'd3);

    // Random requests and occasional RESET
    for (int i = 0; i < 1500; i++) begin
      rr = ($urandom % 7) == 0;
      rs = ($urandom % 5) == 0;
      rx = ($urandom % 60) == 0;
      tick(rr, rs, rx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_asr_sequencer.md
DFF_ASR_SEQUENCER -- requirements
Module: dff_asr_sequencer

Interface
REQ-001 Parameter PULSE_CYCLES, default 2: cycles RESETN/SETN held low per pulse; SHALL be 1..2^CNT_W-1.
REQ-002 Parameter RECOVERY_CYCLES, default 2: cycles after pulse release before capture is enabled; SHALL be 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 4: width of the shared down-counter.
REQ-004 CLK  input  1  single clock; all state SHALL update on posedge CLK only.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 req_reset  input  1  request one clear pulse on downstream async flops.
REQ-007 req_set  input  1  request one preset pulse on downstream async flops.
REQ-008 RESETN  output  1  active-low clear driven to the flops' RESETN pins.
REQ-009 SETN  output  1  active-low preset driven to the flops' SETN pins.
REQ-010 d_en  output  1  high when downstream flops may capture D.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse on entry to IDLE.
REQ-013 drop  output  1  one-cycle pulse when a request is discarded.

Function
REQ-014 States SHALL be IDLE, ASSERT_R, ASSERT_S, RECOVER; all outputs SHALL be registered, decoded from next state.
REQ-015 IDLE: RESETN=1, SETN=1, d_en=1, busy=0.
REQ-016 In IDLE, req_reset sampled high at edge N SHALL drive RESETN=0 from edge N; ASSERT_R loads counter PULSE_CYCLES-1.
REQ-017 In IDLE, req_set alone sampled high SHALL enter ASSERT_S, SETN=0 from edge N, same counter load.
REQ-018 req_reset and req_set both high: reset SHALL win; set handled per REQ-022.
REQ-019 ASSERT_R/ASSERT_S: pin low for exactly PULSE_CYCLES cycles, then RECOVER with RESETN=SETN=1, counter RECOVERY_CYCLES-1.
REQ-020 RECOVER: d_en=0, busy=1 for exactly RECOVERY_CYCLES cycles, then IDLE with done=1 for one cycle.
REQ-021 req_reset during ASSERT_S or RECOVER SHALL preempt: enter ASSERT_R that edge, SETN=1 same edge, counter reloaded.
REQ-022 req_set during ASSERT_R or RECOVER, or req_reset during ASSERT_R: handled per Configuration.
REQ-023 RESETN and SETN SHALL never be low in the same cycle.
REQ-024 d_en SHALL be 0 whenever RESETN=0 or SETN=0.

Reset
REQ-025 RESET high at an edge SHALL force ASSERT_R, counter=PULSE_CYCLES-1, RESETN=0, SETN=1, d_en=0, busy=1, done=0, drop=0, pending flags clear.
REQ-026 While RESET held, state SHALL remain ASSERT_R with counter reloaded; sequence proceeds per REQ-019 from first edge with RESET low.
REQ-027 RESET SHALL override all requests, including mid-pulse and mid-recovery.

Configuration
REQ-028 Macro DFF_ASR_SEQUENCER_PENDING_EN SHALL select request buffering.
REQ-029 Defined: one pending flag per request type; REQ-022 requests SHALL set the flag; on RECOVER exit, pending reset (priority) or set SHALL start next pulse instead of IDLE (no done); duplicates while pending SHALL pulse drop.
REQ-030 Undefined: REQ-022 requests SHALL be discarded with drop=1 for one cycle; no pending storage synthesized.

Verification (PULSE_CYCLES=2, RECOVERY_CYCLES=3)
REQ-031 RESET high 4 cycles, then low -> RESETN=0 for 2 cycles after release, d_en=0 3 more cycles, done pulse, d_en=1, busy=0.
REQ-032 IDLE, req_set pulse at edge 10 -> SETN=0 edges 10-11, RECOVER 12-14, IDLE with done at 15; RESETN stays 1.
REQ-033 req_reset and req_set same edge in IDLE -> RESETN pulse only; set pulses drop (macro off) or follows after RECOVER (macro on).
REQ-034 req_reset mid-ASSERT_S -> SETN=1 and RESETN=0 same edge, RESETN low 2 full cycles; never both low.
REQ-035 RESET asserted during RECOVER -> next edge RESETN=0, d_en=0, pending flags clear, full sequence restarts.
REQ-036 Macro on: req_set twice during ASSERT_R -> first pended and serviced after RECOVER, second pulses drop.
